serial_rx: RTL and testbench



---
 rtl/serterm_pkg.sv | 26 ++
 rtl/rx_fifo.sv | 52 +++++
 rtl/serial_rx.sv | 153 +++++++++++++++
 tb/tb_serial_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serterm_pkg.sv
// Shared definitions for the serial terminal receive path: FSM states,
// oversampling ratio and the sample/decision points within one bit period.
package serterm_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  localparam int unsigned OSR = 16;

  localparam logic [3:0] SMP_LO  = 4'd7;
  localparam logic [3:0] SMP_MID = 4'd8;
  localparam logic [3:0] SMP_HI  = 4'd9;
  localparam logic [3:0] STOP_PT = 4'd9;
  localparam logic [3:0] END_PT  = 4'd15;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only
// when a pop happens in the same cycle.
module rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage is cleared so the head reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority voting and an
// output FIFO presented on a valid/ready interface.
module serial_rx
  import serterm_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DEPTH  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_char,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned DIV = (CLK_HZ + (OSR / 2) * BAUD) / (OSR * BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);

  rx_state_t   state;
  rx_state_t   state_nxt;
  logic        rx_meta;
  logic        rxs;
  logic [CW-1:0] cnt;
  logic        tick;
  logic [3:0]  s;
  logic [2:0]  smp;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        start_c;
  logic        at_end;
  logic        at_stop;
  logic        vote;
  logic        push_c;
  logic        ferr_c;
  logic        shift_c;
  logic        pop;
  logic        full;
  logic        empty;

  // Two-flop synchroniser, idling high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
    end
  end

  assign start_c = (state == RX_IDLE) && !rxs;
  assign tick    = (cnt == DIV_MAX);
  assign at_end  = tick && (s == END_PT);
  assign at_stop = tick && (s == STOP_PT);
  // Third vote comes straight from the line when deciding at the last sample point
  assign vote    = maj3(smp[0], smp[1], (s == SMP_HI) ? rxs : smp[2]);

  // Tick divider, realigned to the start edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)             cnt <= '0;
    else if (start_c || tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  // Sample counter and mid-bit samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s   <= '0;
      smp <= '0;
    end else if (start_c) begin
      s <= '0;
    end else if (tick) begin
      s <= s + 4'd1;
      if (s == SMP_LO)  smp[0] <= rxs;
      if (s == SMP_MID) smp[1] <= rxs;
      if (s == SMP_HI)  smp[2] <= rxs;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RX_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (!rxs)    state_nxt = RX_START;
      RX_START: if (at_end)  state_nxt = vote ? RX_IDLE : RX_DATA;
      RX_DATA:  if (at_end && (idx == 3'd7)) state_nxt = RX_STOP;
      RX_STOP:  if (at_stop) state_nxt = vote ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rxs)     state_nxt = RX_IDLE;
      default:               state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    push_c  = 1'b0;
    ferr_c  = 1'b0;
    shift_c = 1'b0;
    case (state)
      RX_DATA: shift_c = at_end;
      RX_STOP: begin
        push_c = at_stop & vote;
        ferr_c = at_stop & ~vote;
      end
      default: ;
    endcase
  end

  // LSB-first deserialiser
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx   <= '0;
      shreg <= '0;
    end else if ((state == RX_START) && at_end) begin
      idx <= '0;
    end else if (shift_c) begin
      shreg[idx] <= vote;
      idx        <= idx + 3'd1;
    end
  end

  assign pop     = o_valid & i_ready;
  assign o_valid = ~empty;

  rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push_c),
    .pop   (pop),
    .din   (shreg),
    .dout  (o_char),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= ferr_c;
      o_overrun   <= push_c & full & ~pop;
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: frame-level stimulus against a queue
// model of the FIFO whose pushes are scheduled from the frame timing.
module tb_serial_rx;

  localparam int unsigned DEPTH   = 16;
  localparam int          BITCLK  = 160;
  localparam int          PUSH_AT = 1544;

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       good;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] chr;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int         vectors;
  int         miscompares;
  int         ncyc;

  logic [7:0] mq [$];
  ev_t        sched [$];
  ev_t        ev;
  logic       exp_ferr;
  logic       exp_ovr;
  logic       pop_m;
  logic       push_m;
  logic       full_m;
  logic [7:0] rb;
  logic       rstop;

  serial_rx #(.CLK_HZ(1_600_000), .BAUD(10_000), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_char      (chr),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (ferr),
    .o_overrun   (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, ncyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rdy_mode: 0 keep ready, 1 random ready each clock, 2 one-clock ready on the push edge
  task automatic send_frame(input logic [7:0] b, input logic stop, input int spike_t,
                            input int rdy_mode, input int rst_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    sched.push_back('{at: ncyc + PUSH_AT, data: b, good: stop});
    for (int t = 0; t < 10 * BITCLK; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (t == rst_at) begin
        rst_n = 1'b0;
        rx    = 1'b1;
        break;
      end
      rx = fr[t / BITCLK];
      if (t == spike_t) rx = 1'b1;
      if (rdy_mode == 1) ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 2) begin
        if (t == PUSH_AT - 2) ready = 1'b1;
        else if (t == PUSH_AT - 1) ready = 1'b0;
      end
    end
  endtask

  // Reference model: FIFO contents as a queue, updated at each clock edge
  initial begin
    ncyc = 0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_char", 32'(chr), 32'd0);
        check("rst_frame_err", 32'(ferr), 32'd0);
        check("rst_overrun", 32'(ovr), 32'd0);
        mq.delete();
        sched.delete();
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
      end else begin
        check("valid", 32'(valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("char", 32'(chr), 32'(mq[0]));
        check("frame_err", 32'(ferr), 32'(exp_ferr));
        check("overrun", 32'(ovr), 32'(exp_ovr));
        pop_m  = (mq.size() != 0) && ready;
        push_m = 1'b0;
        exp_ferr = 1'b0;
        if (sched.size() != 0 && sched[0].at == ncyc + 1) begin
          ev = sched.pop_front();
          push_m = ev.good;
          exp_ferr = ~ev.good;
        end
        full_m  = (mq.size() == DEPTH);
        exp_ovr = push_m && full_m && !pop_m;
        if (pop_m) void'(mq.pop_front());
        if (push_m && !exp_ovr) mq.push_back(ev.data);
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    rx = 1'b1;
    ready = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(20);

    ready = 1'b1;
    send_frame(8'h41, 1'b1, -1, 0, -1);
    idle(100);

    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(300);

    send_frame(8'h00, 1'b1, 4 * BITCLK + 90, 0, -1);
    idle(100);

    send_frame(8'h55, 1'b0, -1, 0, -1);
    idle(3 * BITCLK);
    rx = 1'b1;
    idle(300);
    send_frame(8'h0D, 1'b1, -1, 0, -1);
    idle(100);

    ready = 1'b0;
    for (int i = 0; i < 17; i++) send_frame(8'(8'h30 + i), 1'b1, -1, 0, -1);
    idle(50);
    send_frame(8'h41, 1'b1, -1, 2, -1);
    idle(50);
    send_frame(8'h42, 1'b1, -1, 0, -1);
    idle(50);
    ready = 1'b1;
    idle(40);

    send_frame(8'hAA, 1'b1, -1, 0, 5 * BITCLK + 80);
    idle(20);
    rst_n = 1'b1;
    idle(300);
    send_frame(8'h7E, 1'b1, -1, 0, -1);
    idle(100);

    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      send_frame(rb, rstop, -1, 1, -1);
      if (!rstop) begin
        rx = 1'b1;
        idle(250);
      end else begin
        idle($urandom_range(0, 40));
      end
    end
    ready = 1'b1;
    idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
